// File: rtl/shift_issue.sv
`default_nettype none
// ============================================================================
//  Module   : shift_issue
//  Purpose  : EX-stage issue register for the barrel shifter. Decodes the shift
//             class, forwards from EX/MEM, and buffers two entries (main+skid).
//  Revision : 1.0  initial release
// ============================================================================
module shift_issue (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IR,
    input  logic [31:0] RS1_VAL,
    input  logic [31:0] RS2_VAL,
    input  logic        ID_VALID,
    output logic        ID_READY,
    input  logic        FWD_EN,
    input  logic [4:0]  FWD_RD,
    input  logic [31:0] FWD_VAL,
    input  logic        FLUSH,
    input  logic        EX_READY,
    output logic        EX_VALID,
    output logic [31:0] IN0,
    output logic [4:0]  S,
    output logic [1:0]  S2,
    output logic [4:0]  RD,
    output logic        SHIFT
);

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_SLLI    = 6'h14;
    localparam logic [5:0] OPC_SRLI    = 6'h16;
    localparam logic [5:0] OPC_SRAI    = 6'h17;
    localparam logic [5:0] FN_SLL      = 6'h04;
    localparam logic [5:0] FN_SRL      = 6'h06;
    localparam logic [5:0] FN_SRA      = 6'h07;

    localparam logic [1:0] S2_NONE     = 2'b00;
    localparam logic [1:0] S2_SLL      = 2'b01;
    localparam logic [1:0] S2_SRL      = 2'b10;
    localparam logic [1:0] S2_SRA      = 2'b11;

    typedef struct packed {
        logic [31:0] in0;
        logic [4:0]  s;
        logic [1:0]  s2;
        logic [4:0]  rd;
        logic        shift;
    } entry_t;

    // ------------------------------------------------------------------
    // Capture-cycle decode and forwarding
    // ------------------------------------------------------------------
    logic [5:0]  w_opcode;
    logic [5:0]  w_func;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_fwd_rs1;
    logic        w_fwd_rs2;
    logic [31:0] w_rs1_val;
    logic [4:0]  w_rs2_amt;
    entry_t      w_in_entry;
    logic        w_unused;

    assign w_opcode  = IR[31:26];
    assign w_func    = IR[5:0];
    assign w_rs1     = IR[25:21];
    assign w_rs2     = IR[20:16];

    // r0 is hard-wired to zero, so it is never a forwarding target
    assign w_fwd_rs1 = FWD_EN && (FWD_RD != 5'd0) && (FWD_RD == w_rs1);
    assign w_fwd_rs2 = FWD_EN && (FWD_RD != 5'd0) && (FWD_RD == w_rs2);
    assign w_rs1_val = w_fwd_rs1 ? FWD_VAL      : RS1_VAL;
    assign w_rs2_amt = w_fwd_rs2 ? FWD_VAL[4:0] : RS2_VAL[4:0];

    assign w_unused  = ^{IR[10:6], RS2_VAL[31:5]};

    always_comb begin
        w_in_entry       = '0;
        w_in_entry.in0   = w_rs1_val;
        if (w_opcode == OPC_SPECIAL) begin
            unique case (w_func)
                FN_SLL:  w_in_entry.s2 = S2_SLL;
                FN_SRL:  w_in_entry.s2 = S2_SRL;
                FN_SRA:  w_in_entry.s2 = S2_SRA;
                default: w_in_entry.s2 = S2_NONE;
            endcase
            if (w_in_entry.s2 != S2_NONE) begin
                w_in_entry.s     = w_rs2_amt;
                w_in_entry.rd    = IR[15:11];
                w_in_entry.shift = 1'b1;
            end
        end else begin
            unique case (w_opcode)
                OPC_SLLI: w_in_entry.s2 = S2_SLL;
                OPC_SRLI: w_in_entry.s2 = S2_SRL;
                OPC_SRAI: w_in_entry.s2 = S2_SRA;
                default:  w_in_entry.s2 = S2_NONE;
            endcase
            if (w_in_entry.s2 != S2_NONE) begin
                w_in_entry.s     = IR[4:0];
                w_in_entry.rd    = IR[20:16];
                w_in_entry.shift = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Main + skid buffer
    // ------------------------------------------------------------------
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   id_ready_q, id_ready_d;
    logic   w_in_fire;
    logic   w_out_fire;

    assign w_in_fire  = ID_VALID && id_ready_q;
    assign w_out_fire = main_vld_q && EX_READY;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (FLUSH) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || w_out_fire) begin
            // skid entry is older than anything arriving now, so it wins
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (w_in_fire) begin
                main_d     = w_in_entry;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (w_in_fire) begin
            skid_d     = w_in_entry;
            skid_vld_d = 1'b1;
        end
        // Ready is a pure function of next occupancy: no EX_READY path to ID
        id_ready_d = !skid_vld_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            id_ready_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            id_ready_q <= id_ready_d;
        end
    end

    assign ID_READY = id_ready_q;
    assign EX_VALID = main_vld_q;
    assign IN0      = main_q.in0;
    assign S        = main_q.s;
    assign S2       = main_q.s2;
    assign RD       = main_q.rd;
    assign SHIFT    = main_q.shift;

endmodule
`default_nettype wire

// File: tb/tb_shift_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_issue
//  Purpose  : Scoreboard bench for shift_issue: directed cases plus randomized
//             traffic checked against a behavioural decode/FIFO model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_issue;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] IR = '0, RS1_VAL = '0, RS2_VAL = '0, FWD_VAL = '0;
    logic        ID_VALID = 1'b0, FWD_EN = 1'b0, FLUSH = 1'b0, EX_READY = 1'b1;
    logic [4:0]  FWD_RD = '0;
    logic        ID_READY, EX_VALID, SHIFT;
    logic [31:0] IN0;
    logic [4:0]  S, RD;
    logic [1:0]  S2;

    shift_issue dut (
        .CLK(CLK), .RST(RST), .IR(IR), .RS1_VAL(RS1_VAL), .RS2_VAL(RS2_VAL),
        .ID_VALID(ID_VALID), .ID_READY(ID_READY), .FWD_EN(FWD_EN),
        .FWD_RD(FWD_RD), .FWD_VAL(FWD_VAL), .FLUSH(FLUSH),
        .EX_READY(EX_READY), .EX_VALID(EX_VALID), .IN0(IN0), .S(S),
        .S2(S2), .RD(RD), .SHIFT(SHIFT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] in0;
        logic [4:0]  s;
        logic [1:0]  s2;
        logic [4:0]  rd;
        logic        shift;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic rst_last = 1'b1;
    logic dir_use  = 1'b0;
    exp_t dir_exp  = '0;

    function automatic exp_t mk(input logic [31:0] in0, input logic [4:0] s,
                                input logic [1:0] s2, input logic [4:0] rd,
                                input logic sh);
        exp_t e;
        e.in0 = in0; e.s = s; e.s2 = s2; e.rd = rd; e.shift = sh;
        return e;
    endfunction

    // Reference: what an issued DLX instruction should present to the shifter
    function automatic exp_t model(input logic [31:0] ir, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic fen,
                                   input logic [4:0] frd, input logic [31:0] fv);
        int unsigned opc, fn, src1, src2, kind;
        logic [31:0] a, b;
        opc  = ir[31:26];
        fn   = ir[5:0];
        src1 = ir[25:21];
        src2 = ir[20:16];
        a = (fen && frd != 0 && frd == src1) ? fv : r1;
        b = (fen && frd != 0 && frd == src2) ? fv : r2;
        kind = 0;
        if (opc == 0) begin
            if (fn == 4) kind = 1;
            if (fn == 6) kind = 2;
            if (fn == 7) kind = 3;
            if (kind != 0) return mk(a, 5'(b % 32), 2'(kind), ir[15:11], 1'b1);
        end else begin
            if (opc == 'h14) kind = 1;
            if (opc == 'h16) kind = 2;
            if (opc == 'h17) kind = 3;
            if (kind != 0) return mk(a, ir[4:0], 2'(kind), ir[20:16], 1'b1);
        end
        return mk(a, 5'd0, 2'd0, 5'd0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Monitor: inputs change on negedge; sample everything 2 time units later
    always @(negedge CLK) begin
        #2;
        chk("ID_READY", 64'(ID_READY), 64'(!rst_last && sb.size() < 2));
        chk("EX_VALID", 64'(EX_VALID), 64'(!rst_last && sb.size() > 0));
        if (rst_last) begin
            chk("RST_OUT", {IN0, S, S2, RD, SHIFT}, 64'd0);
        end else if (EX_VALID && sb.size() > 0) begin
            chk("IN0",   64'(IN0),   64'(sb[0].in0));
            chk("S",     64'(S),     64'(sb[0].s));
            chk("S2",    64'(S2),    64'(sb[0].s2));
            chk("RD",    64'(RD),    64'(sb[0].rd));
            chk("SHIFT", 64'(SHIFT), 64'(sb[0].shift));
        end
        if (RST || FLUSH) begin
            sb.delete();
        end else begin
            if (EX_VALID && EX_READY && sb.size() > 0) void'(sb.pop_front());
            if (ID_VALID && ID_READY)
                sb.push_back(dir_use ? dir_exp
                             : model(IR, RS1_VAL, RS2_VAL, FWD_EN, FWD_RD, FWD_VAL));
        end
        rst_last = RST;
    end

    // Present one instruction and hold it until accepted; returns at a negedge
    task automatic send(input logic [31:0] ir, input logic [31:0] r1,
                        input logic [31:0] r2, input logic fen,
                        input logic [4:0] frd, input logic [31:0] fv,
                        input logic use_d, input exp_t de);
        logic acc;
        int   t;
        IR = ir; RS1_VAL = r1; RS2_VAL = r2;
        FWD_EN = fen; FWD_RD = frd; FWD_VAL = fv;
        dir_use = use_d; dir_exp = de; ID_VALID = 1'b1;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 50) begin
            #1 acc = ID_READY;
            @(negedge CLK);
            t++;
        end
        if (!acc) begin
            n_checks++;
            $display("FAIL accept_timeout: ID_READY stuck 0 for %0d cycles", t);
        end
    endtask

    task automatic idle(input int n);
        ID_VALID = 1'b0; FWD_EN = 1'b0; dir_use = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    localparam logic [31:0] SLLI_R3_R1_5 = 32'h5023_0005;
    localparam logic [31:0] SRA_R4_R2_R5 = 32'h0045_2007;
    localparam logic [31:0] ADD_R3_R1_R2 = 32'h0022_1820;

    initial begin
        int t;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        send(SLLI_R3_R1_5, 32'h1, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
             mk(32'h1, 5'd5, 2'b01, 5'd3, 1'b1));
        send(SRA_R4_R2_R5, 32'h8000_0000, 32'h124, 1'b0, 5'd0, 32'h0, 1'b1,
             mk(32'h8000_0000, 5'd4, 2'b11, 5'd4, 1'b1));
        send(SRA_R4_R2_R5, 32'h8000_0000, 32'h124, 1'b1, 5'd5, 32'h1F, 1'b1,
             mk(32'h8000_0000, 5'd31, 2'b11, 5'd4, 1'b1));
        send(SRA_R4_R2_R5, 32'h8000_0000, 32'h124, 1'b1, 5'd0, 32'h1F, 1'b1,
             mk(32'h8000_0000, 5'd4, 2'b11, 5'd4, 1'b1));
        send(ADD_R3_R1_R2, 32'hDEAD_BEEF, 32'h7, 1'b0, 5'd0, 32'h0, 1'b1,
             mk(32'hDEAD_BEEF, 5'd0, 2'b00, 5'd0, 1'b0));
        idle(3);

        // Back-pressure: A held, B in skid, C blocked until release
        EX_READY = 1'b0;
        fork
            begin
                send(32'h5020_000A, 32'hA, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                     mk(32'hA, 5'd10, 2'b01, 5'd0, 1'b1));
                send(32'h5C41_0003, 32'hB, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                     mk(32'hB, 5'd3, 2'b11, 5'd1, 1'b1));
                send(32'h5862_0011, 32'hC, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                     mk(32'hC, 5'd17, 2'b10, 5'd2, 1'b1));
                idle(1);
            end
            begin
                repeat (5) @(negedge CLK);
                EX_READY = 1'b1;
            end
        join
        idle(4);

        // FLUSH with two buffered and a third presented
        EX_READY = 1'b0;
        send(32'h5020_0001, 32'h11, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, '0);
        send(32'h5020_0002, 32'h22, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, '0);
        IR = 32'h5020_0003; RS1_VAL = 32'h33; ID_VALID = 1'b1; FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        idle(2);
        EX_READY = 1'b1;
        idle(3);

        // Reset while stalled and full, then a fresh entry
        EX_READY = 1'b0;
        send(32'h5020_0004, 32'h44, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, '0);
        send(32'h5020_0005, 32'h55, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, '0);
        ID_VALID = 1'b0; RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0; EX_READY = 1'b1;
        send(SLLI_R3_R1_5, 32'h1, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
             mk(32'h1, 5'd5, 2'b01, 5'd3, 1'b1));
        idle(3);

        // Randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] ir;
            int unsigned k;
            k  = $urandom_range(0, 5);
            ir = $urandom;
            ir[25:21] = 5'($urandom_range(0, 7));
            ir[20:16] = 5'($urandom_range(0, 7));
            case (k)
                0, 1: begin
                    ir[31:26] = 6'h00;
                    ir[5:0]   = ($urandom_range(0, 2) == 0) ? 6'h04 :
                                ($urandom_range(0, 1) == 0) ? 6'h06 : 6'h07;
                end
                2, 3: ir[31:26] = ($urandom_range(0, 2) == 0) ? 6'h14 :
                                  ($urandom_range(0, 1) == 0) ? 6'h16 : 6'h17;
                4: begin ir[31:26] = 6'h00; ir[5:0] = 6'h20; end
                default: ;
            endcase
            IR = ir; RS1_VAL = $urandom; RS2_VAL = $urandom;
            FWD_EN = 1'($urandom_range(0, 1));
            FWD_RD = 5'($urandom_range(0, 7));
            FWD_VAL = $urandom;
            dir_use = 1'b0;
            ID_VALID = ($urandom_range(0, 3) != 0);
            EX_READY = ($urandom_range(0, 2) != 0);
            FLUSH = ($urandom_range(0, 39) == 0);
            if (FLUSH) EX_READY = 1'b0;
            RST = ($urandom_range(0, 149) == 0);
            @(negedge CLK);
        end
        FLUSH = 1'b0; RST = 1'b0; EX_READY = 1'b1;
        idle(1);
        t = 0;
        while (sb.size() > 0 && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d entries never emerged", sb.size());
        end
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_issue.md
# shift_issue

Execute-stage issue register feeding the DLX barrel shifter. Decodes the shift class from the instruction word and selects the shift amount from a register or immediate. Applies single-source forwarding from EX/MEM and presents registered IN0/S/S2/RD to the shifter. A two-entry (main + skid) buffer with valid/ready handshakes on both sides decouples the ID stage from back-pressure in EX.

## Interface
Parameters: none.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- IR  in  32  instruction word from ID
- RS1_VAL  in  32  register-file value of IR[25:21]
- RS2_VAL  in  32  register-file value of IR[20:16]
- ID_VALID  in  1  IR/RSx valid this cycle
- ID_READY  out  1  registered; 1 = skid entry empty, transfer accepted
- FWD_EN  in  1  EX/MEM result valid for forwarding
- FWD_RD  in  5  EX/MEM destination register
- FWD_VAL  in  32  EX/MEM result
- FLUSH  in  1  squash all buffered entries (branch/exception)
- EX_READY  in  1  shifter/EX stage accepts the presented entry
- EX_VALID  out  1  IN0/S/S2/RD/SHIFT valid
- IN0  out  32  operand to shift (forwarded rs1)
- S  out  5  shift amount
- S2  out  2  01 SLL, 10 SRL, 11 SRA, 00 non-shift
- RD  out  5  destination register
- SHIFT  out  1  1 = entry is a shift instruction

## Operation
- Decode, opcode = IR[31:26], func = IR[5:0]:
  - opcode 0x00, func 0x04/0x06/0x07: SLL/SRL/SRA. S2 = 01/10/11. S = low 5 bits of forwarded rs2. RD = IR[15:11].
  - opcode 0x14/0x16/0x17: SLLI/SRLI/SRAI. S2 = 01/10/11. S = IR[4:0]. RD = IR[20:16].
  - Anything else: S2 = 00, S = 0, SHIFT = 0, RD = 0. Entry still passes through (IN0 = forwarded rs1).
- Forwarding:
  - rs1 = IR[25:21], rs2 = IR[20:16].
  - If FWD_EN and FWD_RD != 0 and FWD_RD == rsN, use FWD_VAL in place of RSN_VAL.
  - Register 0 is never forwarded.
  - Forwarding is evaluated in the capture cycle only; buffered entries are not re-forwarded.
- Buffer: main register drives the outputs; the skid register holds one overflow entry.
  - Transfer in: ID_VALID & ID_READY.
  - Transfer out: EX_VALID & EX_READY.
  - Main empty, or draining this cycle: the incoming entry (or the skid entry, which has priority) loads main.
  - Main full and stalled: the incoming entry loads skid, and ID_READY drops next cycle.
  - ID_READY rises the cycle after skid drains into main.
  - Order is strictly FIFO; the skid entry always precedes any new input.
- FLUSH, priority over everything:
  - Next cycle EX_VALID = 0, skid empty, ID_READY = 1.
  - An input presented in the FLUSH cycle is dropped.
  - Output data registers hold their old values; they are don't-care while EX_VALID = 0.
- Stalled outputs (EX_VALID & !EX_READY): IN0/S/S2/RD/SHIFT stable, bit-exact.

## Timing
- Reset (RST high at edge): EX_VALID = 0, ID_READY = 0 during and 1 in the first cycle after RST deasserts. IN0 = 0, S = 0, S2 = 00, RD = 0, SHIFT = 0, skid empty.
- Latency: 1 cycle, input accept edge to EX_VALID when main is empty or draining.
- Throughput: 1 entry/cycle sustained while EX_READY = 1.
- Back-pressure:
  - EX_READY low for N cycles with continuous input: exactly 2 entries buffered.
  - ID_READY low from the 2nd stalled acceptance onward.
  - No entry lost or duplicated.
- Simultaneous in/out with skid full: skid → main, input blocked (ID_READY = 0 that cycle).
- RST asserted mid-stall: both entries discarded, reset values next cycle.
- ID_READY depends only on state, with no combinational path from EX_READY. EX_VALID and all data outputs are registered.

## Test plan
- Reset, then IR = SLLI r3,r1,5 (0x50230005), RS1_VAL = 0x0000_0001, EX_READY = 1 → next cycle EX_VALID = 1, IN0 = 0x1, S = 5, S2 = 01, RD = 3, SHIFT = 1.
- SRA r4,r2,r5 with RS2_VAL = 0x0000_0124, RS1_VAL = 0x8000_0000 → S = 0x04, S2 = 11, RD = 4. Repeat with FWD_EN = 1, FWD_RD = 5, FWD_VAL = 0x1F → S = 31. Repeat with FWD_RD = 0 → no forwarding.
- EX_READY = 0 for 5 cycles while issuing A, B, C back-to-back:
  - A held on outputs; B captured in skid.
  - ID_READY = 0 from the cycle after B; C held at input.
  - Release: A, B, C emerge in consecutive cycles.
- FLUSH with two entries buffered and a third presented → next cycle EX_VALID = 0, ID_READY = 1, and none of the three ever appear.
- ADD (opcode 0x00, func 0x20) → EX_VALID = 1, S2 = 00, S = 0, SHIFT = 0, IN0 = RS1_VAL.
- RST pulsed while stalled and full → all outputs at reset values; the first post-reset input emerges correctly after 1 cycle.
